// File: rtl/arb_pkg.sv
// Shared types and defaults for the unified fetch/data memory arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_t;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } owner_t;

    localparam int unsigned STARVE_MAX_DEF = 4;

    function automatic int unsigned ctr_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive data wins taken while fetch was waiting.
module arb_starve_ctr
    import arb_pkg::*;
#(
    parameter int unsigned MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int unsigned W = ctr_width(MAX);
    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_max) begin
            cnt <= cnt + W'(1);
        end
    end

    assign at_max = (cnt == MAX_V);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one fetch and one data port onto a single-outstanding memory bus,
// data preferred, with a bounded number of data wins while fetch waits.
module unified_mem_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ready,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int unsigned BE_W = DATA_W / 8;

    state_t            state, state_nxt;
    owner_t            owner;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    logic [BE_W-1:0]   be_q;
    logic              pick_d, pick_if, at_max, resp_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Grants are gated by rst so nothing is offered while reset is held.
    always_comb begin
        state_nxt = state;
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        pick_d    = d_req && !(if_req && at_max);
        pick_if   = if_req && !pick_d;
        case (state)
            IDLE: begin
                if (rst && (pick_d || pick_if)) begin
                    if_gnt    = pick_if;
                    d_gnt     = pick_d;
                    state_nxt = REQ;
                end
            end
            REQ:     if (mem_ready)  state_nxt = RESP;
            RESP:    if (mem_rvalid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner   <= OWN_IF;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
        end else if (d_gnt) begin
            owner   <= OWN_D;
            addr_q  <= d_addr;
            wdata_q <= d_wdata;
            we_q    <= d_we;
            be_q    <= d_be;
        end else if (if_gnt) begin
            owner   <= OWN_IF;
            addr_q  <= if_addr & ~ADDR_W'(3);
            wdata_q <= '0;
            we_q    <= 1'b0;
            be_q    <= '1;
        end
    end

    arb_starve_ctr #(
        .MAX(STARVE_MAX)
    ) u_starve (
        .clk    (clk),
        .rst    (rst),
        .inc    (d_gnt && if_req),
        .clr    (if_gnt || (d_gnt && !if_req)),
        .at_max (at_max)
    );

    assign mem_req   = (state == REQ);
    assign mem_we    = mem_req && we_q;
    assign mem_be    = mem_req ? be_q    : '0;
    assign mem_addr  = mem_req ? addr_q  : '0;
    assign mem_wdata = mem_req ? wdata_q : '0;

    assign resp_done = (state == RESP) && mem_rvalid;
    assign if_rvalid = resp_done && (owner == OWN_IF);
    assign d_rvalid  = resp_done && (owner == OWN_D);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = d_rvalid  ? mem_rdata : '0;

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed scenarios plus randomized traffic, checked every cycle against a
// transaction-level model of the arbiter.
module tb_unified_mem_arbiter;

    localparam int SM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    unified_mem_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .STARVE_MAX(SM)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding transaction, either waiting for
    // memory acceptance (sent=0) or waiting for its completion (sent=1).
    bit          m_busy, m_sent, m_own_d;
    logic [31:0] m_addr, m_wdata;
    logic        m_we;
    logic [3:0]  m_be;
    int          m_starve;
    logic        pick_d, pick_if;
    logic        e_if_gnt, e_d_gnt, e_if_rv, e_d_rv, e_mreq, e_mwe, e_busy;
    logic [31:0] e_if_rd, e_d_rd, e_maddr, e_mwdata;
    logic [3:0]  e_mbe;

    always @(negedge clk) begin
        {e_if_gnt, e_d_gnt, e_if_rv, e_d_rv, e_mreq, e_mwe, e_busy} = '0;
        {e_if_rd, e_d_rd, e_maddr, e_mwdata} = '0;
        e_mbe = '0;
        pick_d = 1'b0;
        pick_if = 1'b0;
        if (rst === 1'b1) begin
            if (!m_busy) begin
                pick_d  = d_req && !(if_req && m_starve == SM);
                pick_if = if_req && !pick_d;
                e_if_gnt = pick_if;
                e_d_gnt  = pick_d;
            end else if (!m_sent) begin
                e_busy = 1'b1; e_mreq = 1'b1; e_mwe = m_we;
                e_mbe = m_be; e_maddr = m_addr; e_mwdata = m_wdata;
            end else begin
                e_busy = 1'b1;
                if (mem_rvalid) begin
                    if (m_own_d) begin e_d_rv = 1'b1; e_d_rd = mem_rdata; end
                    else begin e_if_rv = 1'b1; e_if_rd = mem_rdata; end
                end
            end
        end
        check("m_if_gnt", if_gnt, e_if_gnt);
        check("m_d_gnt", d_gnt, e_d_gnt);
        check("m_if_rvalid", if_rvalid, e_if_rv);
        check("m_if_rdata", if_rdata, e_if_rd);
        check("m_d_rvalid", d_rvalid, e_d_rv);
        check("m_d_rdata", d_rdata, e_d_rd);
        check("m_mem_req", mem_req, e_mreq);
        check("m_mem_we", mem_we, e_mwe);
        check("m_mem_be", mem_be, e_mbe);
        check("m_mem_addr", mem_addr, e_maddr);
        check("m_mem_wdata", mem_wdata, e_mwdata);
        check("m_busy", busy, e_busy);
        // Advance the model through the coming rising edge.
        if (rst !== 1'b1) begin
            m_busy = 0; m_sent = 0; m_own_d = 0; m_starve = 0;
            m_addr = '0; m_wdata = '0; m_we = 0; m_be = '0;
        end else if (!m_busy) begin
            if (pick_d || pick_if) begin
                m_busy = 1; m_sent = 0; m_own_d = pick_d;
                if (pick_d) begin
                    m_addr = d_addr; m_wdata = d_wdata; m_we = d_we; m_be = d_be;
                end else begin
                    m_addr = if_addr & 32'hFFFF_FFFC; m_wdata = '0; m_we = 0; m_be = 4'hF;
                end
                if (pick_if || !if_req) m_starve = 0;
                else if (m_starve < SM) m_starve = m_starve + 1;
            end
        end else if (!m_sent) begin
            if (mem_ready) m_sent = 1;
        end else if (mem_rvalid) begin
            m_busy = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic serve(input logic [31:0] rdata, input bit drop);
        step(); mem_ready = 1'b1;
        step(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = rdata;
        step(); mem_rvalid = 1'b0;
        if (drop) begin if_req = 1'b0; d_req = 1'b0; end
    endtask

    logic [5:0] pattern;
    logic       g_if, g_d;

    initial begin
        rst = 1'b0; if_req = 1'b1; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (2) step();
        #3;
        check("rst_if_gnt", if_gnt, 0);
        check("rst_busy", busy, 0);
        check("rst_mem_req", mem_req, 0);

        // Fetch only, immediate memory.
        step(); rst = 1'b1; if_req = 1'b1; if_addr = 32'h0000_0010; #3;
        check("f_if_gnt", if_gnt, 1);
        check("f_d_gnt", d_gnt, 0);
        step(); if_req = 1'b0; if_addr = '0; mem_ready = 1'b1; #3;
        check("f_mem_req", mem_req, 1);
        check("f_mem_we", mem_we, 0);
        check("f_mem_be", mem_be, 4'hF);
        check("f_mem_addr", mem_addr, 32'h10);
        check("f_if_gnt_req", if_gnt, 0);
        step(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h13; #3;
        check("f_if_rvalid", if_rvalid, 1);
        check("f_if_rdata", if_rdata, 32'h13);
        check("f_d_rvalid", d_rvalid, 0);
        check("f_mem_req_resp", mem_req, 0);
        step(); mem_rvalid = 1'b0; #3;
        check("f_busy_idle", busy, 0);

        // Simultaneous requests: data first, fetch on the next IDLE.
        step();
        if_req = 1'b1; if_addr = 32'h0000_0023;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_be = 4'h3; #3;
        check("s_d_gnt", d_gnt, 1);
        check("s_if_gnt", if_gnt, 0);
        step(); d_req = 1'b0; mem_ready = 1'b1; #3;
        check("s_mem_addr", mem_addr, 32'h100);
        check("s_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("s_mem_be", mem_be, 4'h3);
        check("s_mem_we", mem_we, 1);
        step(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h5; #3;
        check("s_d_rvalid", d_rvalid, 1);
        check("s_if_rvalid", if_rvalid, 0);
        step(); mem_rvalid = 1'b0; #3;
        check("s_if_gnt_next", if_gnt, 1);
        serve(32'h7, 1'b0);

        // Starvation: both held high through six arbitration rounds.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_be = 4'hF;
        for (int i = 0; i < 6; i++) begin
            #3;
            pattern[i] = d_gnt;
            check("st_onehot", if_gnt ^ d_gnt, 1);
            serve(32'h100 + 32'(i), i == 5);
        end
        check("st_pattern", pattern, 6'b101111);

        // Wait states.
        #3; step();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_be = 4'hF; #3;
        check("w_d_gnt", d_gnt, 1);
        step(); d_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mem_ready = (k == 3); #3;
            check("w_mem_req", mem_req, 1);
            check("w_mem_addr", mem_addr, 32'h40);
            check("w_busy", busy, 1);
            step();
        end
        mem_ready = 1'b0; #3;
        check("w_rv_early", d_rvalid, 0);
        check("w_busy_resp", busy, 1);
        step(); mem_rvalid = 1'b1; mem_rdata = 32'hCAFE; #3;
        check("w_d_rvalid", d_rvalid, 1);
        check("w_d_rdata", d_rdata, 32'hCAFE);
        step(); mem_rvalid = 1'b0; #3;
        check("w_rv_after", d_rvalid, 0);
        check("w_busy_done", busy, 0);

        // Reset while waiting for completion.
        step(); if_req = 1'b1; if_addr = 32'h80; #3;
        check("r_if_gnt", if_gnt, 1);
        step(); if_req = 1'b0; mem_ready = 1'b1;
        step(); mem_ready = 1'b0; #3;
        check("r_busy_resp", busy, 1);
        rst = 1'b0; #2;
        check("r_busy_in_rst", busy, 0);
        step(); rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h99; #3;
        check("r_if_rvalid", if_rvalid, 0);
        check("r_d_rvalid", d_rvalid, 0);
        check("r_busy", busy, 0);

        // Spurious completion in IDLE.
        step(); mem_rvalid = 1'b1; #3;
        check("sp_if_rvalid", if_rvalid, 0);
        check("sp_d_rvalid", d_rvalid, 0);
        step(); mem_rvalid = 1'b0; #3;
        check("sp_busy", busy, 0);

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            g_if = if_gnt; g_d = d_gnt;
            step();
            if (!if_req || g_if) begin
                if_req  = ($urandom_range(0, 2) != 0);
                if_addr = $urandom;
            end
            if (!d_req || g_d) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_we    = $urandom_range(0, 1);
                d_be    = 4'($urandom);
                d_addr  = $urandom;
                d_wdata = $urandom;
            end
            mem_ready  = ($urandom_range(0, 3) != 0);
            mem_rvalid = $urandom_range(0, 1);
            mem_rdata  = $urandom;
            rst        = ($urandom_range(0, 299) != 0);
            #3;
        end
        step(); rst = 1'b1; if_req = 1'b0; d_req = 1'b0;
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
